// File: rtl/aec_expr_tx.sv
// Transmit side of the AEC ASCII expression interface: buffers a host expression and streams it to the AEC.
// Optional result checking (exp_in/pass/fail) is built when AEC_TX_CHECK_EN is defined.
module aec_expr_tx #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_char,
    input  logic       start,
    output logic       full,
    output logic       busy,
    output logic       ready,
    output logic [7:0] ascii_out,
    input  logic       valid_in,
    input  logic [6:0] result_in,
    output logic       done,
    output logic [6:0] result_out,
    output logic       timeout_err,
    input  logic [6:0] exp_in,
    output logic       pass,
    output logic       fail
);
    localparam int unsigned CW      = AW + 1;
    localparam logic [7:0]  EQ_CHAR = 8'h3D;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_APPEND, S_WAIT} state_t;
    state_t state, state_nx;

    logic [7:0]    buffer [DEPTH];
    logic [CW-1:0] count, count_nx;
    logic [AW-1:0] rd_ptr, rd_ptr_nx;
    logic [7:0]    wait_cnt, wait_nx;
    logic [7:0]    ascii_nx, first_byte;
    logic [6:0]    result_nx;
    logic          ready_nx, done_nx, tmo_nx;
    logic          wr_ok, go, last_byte, eq_seen, expire;

    // A byte written together with start at an empty buffer is forwarded as the first byte.
    assign wr_ok      = (state == S_IDLE) && wr_en && !full;
    assign go         = (state == S_IDLE) && start && ((count != '0) || wr_ok);
    assign first_byte = (count == '0) ? wr_char : buffer[0];
    assign last_byte  = (CW'(rd_ptr) + CW'(1)) == count;
    assign eq_seen    = (ascii_out == EQ_CHAR);
    assign expire     = (wait_cnt == 8'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (go) state_nx = S_SEND;
            S_SEND:   if (eq_seen) state_nx = S_WAIT;
                      else if (last_byte) state_nx = S_APPEND;
            S_APPEND: state_nx = S_WAIT;
            S_WAIT:   if (valid_in || expire) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath
    always_comb begin
        ascii_nx  = ascii_out;
        ready_nx  = 1'b0;
        rd_ptr_nx = rd_ptr;
        count_nx  = count;
        wait_nx   = '0;
        done_nx   = 1'b0;
        tmo_nx    = 1'b0;
        result_nx = result_out;
        case (state)
            S_IDLE: begin
                if (wr_ok) count_nx = count + CW'(1);
                if (go) begin
                    ascii_nx  = first_byte;
                    ready_nx  = 1'b1;
                    rd_ptr_nx = '0;
                end
            end
            S_SEND: begin
                if (!eq_seen) begin
                    if (last_byte) begin
                        ascii_nx = EQ_CHAR;
                    end else begin
                        rd_ptr_nx = rd_ptr + AW'(1);
                        ascii_nx  = buffer[rd_ptr + AW'(1)];
                    end
                end
            end
            S_WAIT: begin
                wait_nx = wait_cnt + 8'd1;
                if (valid_in) begin
                    result_nx = result_in;
                    done_nx   = 1'b1;
                end else if (expire) begin
                    tmo_nx = 1'b1;
                end
                if (valid_in || expire) begin
                    count_nx  = '0;
                    rd_ptr_nx = '0;
                    ascii_nx  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            rd_ptr      <= '0;
            wait_cnt    <= '0;
            ascii_out   <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            full        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            result_out  <= '0;
        end else begin
            count       <= count_nx;
            rd_ptr      <= rd_ptr_nx;
            wait_cnt    <= wait_nx;
            ascii_out   <= ascii_nx;
            ready       <= ready_nx;
            busy        <= (state_nx != S_IDLE);
            full        <= (count_nx == CW'(DEPTH));
            done        <= done_nx;
            timeout_err <= tmo_nx;
            result_out  <= result_nx;
        end
    end

    // Expression storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (wr_ok) buffer[count[AW-1:0]] <= wr_char;
    end

`ifdef AEC_TX_CHECK_EN
    logic [6:0] exp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q <= '0;
            pass  <= 1'b0;
            fail  <= 1'b0;
        end else begin
            if (go) exp_q <= exp_in;
            pass <= (state == S_WAIT) && valid_in && (result_in == exp_q);
            fail <= (state == S_WAIT) && (valid_in ? (result_in != exp_q) : expire);
        end
    end
`else
    logic unused_exp;
    assign unused_exp = ^exp_in;
    assign pass       = 1'b0;
    assign fail       = 1'b0;
`endif

endmodule

// File: tb/tb_aec_expr_tx.sv
// Self-checking bench for aec_expr_tx: directed vector table, corner sequences and random expressions
// compared against a stream/result model derived from the expression rules.
module tb_aec_expr_tx;
    localparam int unsigned DEPTH   = 32;
    localparam int unsigned AW      = 5;
    localparam int unsigned TIMEOUT = 255;

    logic       clk, rst, wr_en, start, valid_in;
    logic [7:0] wr_char;
    logic [6:0] result_in, exp_in;
    logic       full, busy, ready, done, timeout_err, pass, fail;
    logic [7:0] ascii_out;
    logic [6:0] result_out;

    aec_expr_tx #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_char(wr_char), .start(start),
        .full(full), .busy(busy), .ready(ready), .ascii_out(ascii_out),
        .valid_in(valid_in), .result_in(result_in), .done(done),
        .result_out(result_out), .timeout_err(timeout_err),
        .exp_in(exp_in), .pass(pass), .fail(fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_b [DEPTH+1];
    int         tx_len;
    logic [7:0] ex_s [DEPTH+1];
    int         ex_len;
    logic [6:0] model_res = '0;
    logic [6:0] cur_exp   = '0;

    typedef struct packed {
        int          len;
        logic [63:0] b;
        int          slen;
        logic [71:0] s;
        int          dly;
        logic [6:0]  res;
        logic [6:0]  ex;
        logic        same;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected AEC stream: bytes up to and including the first '=', else all bytes plus '='.
    function automatic void model_stream();
        ex_len = 0;
        for (int i = 0; i < tx_len; i++) begin
            ex_s[ex_len] = tx_b[i];
            ex_len++;
            if (tx_b[i] == 8'h3D) return;
        end
        ex_s[ex_len] = 8'h3D;
        ex_len++;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_ascii"}, 32'(ascii_out), 32'd0);
        check({tag, "_full"},  32'(full), 32'd0);
    endtask

    task automatic do_load_start(input logic same, input logic [6:0] e);
        cur_exp = e;
        for (int i = 0; i < tx_len; i++) begin
            wr_en = 1'b1; wr_char = tx_b[i];
            if (same && i == tx_len - 1) begin start = 1'b1; exp_in = e; end
            tick();
        end
        wr_en = 1'b0;
        if (!same) begin start = 1'b1; exp_in = e; tick(); end
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Stream check with ignored junk (writes, starts, valids) on the inputs.
    task automatic do_stream();
        for (int k = 0; k < ex_len; k++) begin
            check("ascii_stream", 32'(ascii_out), 32'(ex_s[k]));
            check("ready_stream", 32'(ready), 32'(k == 0));
            wr_en     = 1'($urandom_range(0, 1));
            wr_char   = 8'h3D;
            start     = 1'($urandom_range(0, 1));
            valid_in  = 1'($urandom_range(0, 1));
            result_in = 7'($urandom);
            tick();
        end
        wr_en = 1'b0; start = 1'b0; valid_in = 1'b0;
    endtask

    // dly < 0 means no valid_in: the wait must expire.
    task automatic do_wait(input int dly, input logic [6:0] res);
        logic ep, ef;
        if (dly < 0) begin
            for (int j = 0; j < int'(TIMEOUT) - 1; j++) tick();
            check("wait_hold_ascii", 32'(ascii_out), 32'h3D);
            check("wait_busy", 32'(busy), 32'd1);
            check("no_early_timeout", 32'(timeout_err), 32'd0);
            tick();
            check("timeout_pulse", 32'(timeout_err), 32'd1);
            check("timeout_busy", 32'(busy), 32'd0);
            check("timeout_keep_res", 32'(result_out), 32'(model_res));
            check("timeout_no_done", 32'(done), 32'd0);
            check("timeout_ascii0", 32'(ascii_out), 32'd0);
`ifdef AEC_TX_CHECK_EN
            ef = 1'b1;
`else
            ef = 1'b0;
`endif
            check("timeout_fail", 32'(fail), 32'(ef));
            check("timeout_pass", 32'(pass), 32'd0);
            tick();
            check("timeout_one_cycle", 32'(timeout_err), 32'd0);
        end else begin
            for (int j = 0; j < dly; j++) tick();
            check("wait_hold_ascii", 32'(ascii_out), 32'h3D);
            check("wait_ready0", 32'(ready), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
            valid_in = 1'b1; result_in = res;
            tick();
            valid_in = 1'b0;
            model_res = res;
`ifdef AEC_TX_CHECK_EN
            ep = (res == cur_exp);
            ef = !ep;
`else
            ep = 1'b0;
            ef = 1'b0;
`endif
            check("done_pulse", 32'(done), 32'd1);
            check("result_out", 32'(result_out), 32'(model_res));
            check("done_no_timeout", 32'(timeout_err), 32'd0);
            check("pass", 32'(pass), 32'(ep));
            check("fail", 32'(fail), 32'(ef));
            check_idle_zero("after_done");
            tick();
            check("done_one_cycle", 32'(done), 32'd0);
            check("pass_one_cycle", 32'(pass), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [6:0] res, e;
        wr_en = 1'b0; wr_char = '0; start = 1'b0; valid_in = 1'b0;
        result_in = '0; exp_in = '0;

        rst = 1'b0;
        #12;
        check_idle_zero("reset");
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result_out), 32'd0);
        check("reset_timeout", 32'(timeout_err), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_fail", 32'(fail), 32'd0);
        @(negedge clk); rst = 1'b1;
        tick();

        vecs[0] = '{len:4, b:64'h3D322B31, slen:4, s:72'h3D322B31,   dly:3,   res:7'd3,  ex:7'd3,  same:1'b0};
        vecs[1] = '{len:3, b:64'h00352A34, slen:4, s:72'h3D352A34,   dly:0,   res:7'd20, ex:7'd20, same:1'b1};
        vecs[2] = '{len:3, b:64'h00373D39, slen:2, s:72'h00003D39,   dly:5,   res:7'd2,  ex:7'd3,  same:1'b0};
        vecs[3] = '{len:4, b:64'h3D352B35, slen:4, s:72'h3D352B35,   dly:254, res:7'd10, ex:7'd10, same:1'b0};
        vecs[4] = '{len:1, b:64'h00000037, slen:2, s:72'h00003D37,   dly:1,   res:7'd7,  ex:7'd7,  same:1'b1};
        vecs[5] = '{len:3, b:64'h00312D38, slen:4, s:72'h3D312D38,   dly:-1,  res:7'd0,  ex:7'd9,  same:1'b0};
        vecs[6] = '{len:1, b:64'h0000003D, slen:1, s:72'h0000003D,   dly:0,   res:7'd0,  ex:7'd0,  same:1'b0};

        for (int n = 0; n < 7; n++) begin
            v = vecs[n];
            tx_len = v.len;
            for (int i = 0; i < tx_len; i++) tx_b[i] = v.b[8*i +: 8];
            ex_len = v.slen;
            for (int i = 0; i < ex_len; i++) ex_s[i] = v.s[8*i +: 8];
            do_load_start(v.same, v.ex);
            do_stream();
            do_wait(v.dly, v.res);
        end

        // Empty buffer start is ignored.
        start = 1'b1; tick(); start = 1'b0;
        check("empty_start_busy", 32'(busy), 32'd0);
        tick();
        check("empty_start_busy2", 32'(busy), 32'd0);

        // Overfill: the extra '=' is dropped, so the 32 bytes are sent with an appended '='.
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            wr_en = 1'b1; wr_char = (i < int'(DEPTH)) ? 8'h31 : 8'h3D;
            tick();
            check("full_flag", 32'(full), 32'(i + 1 >= int'(DEPTH)));
        end
        wr_en = 1'b0;
        tx_len = DEPTH;
        for (int i = 0; i < int'(DEPTH); i++) tx_b[i] = 8'h31;
        model_stream();
        start = 1'b1; exp_in = 7'd9; cur_exp = 7'd9; tick(); start = 1'b0;
        do_stream();
        do_wait(2, 7'd9);

        // Mid-SEND asynchronous reset.
        tx_len = 6;
        for (int i = 0; i < 6; i++) tx_b[i] = 8'h31 + 8'(i);
        do_load_start(1'b0, 7'd0);
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        check_idle_zero("async_reset");
        check("async_reset_result", 32'(result_out), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        @(negedge clk); rst = 1'b1;
        model_res = '0;
        tick();
        for (int r = 0; r < 2; r++) begin
            tx_len = 4;
            tx_b[0] = 8'h32; tx_b[1] = 8'h2D; tx_b[2] = 8'h31; tx_b[3] = 8'h3D;
            model_stream();
            do_load_start(1'b0, (r == 0) ? 7'd1 : 7'd5);
            do_stream();
            do_wait(1, 7'd1);
        end

        // Random expressions against the stream model.
        for (int t = 0; t < 40; t++) begin
            tx_len = $urandom_range(1, 12);
            for (int i = 0; i < tx_len; i++)
                tx_b[i] = ($urandom_range(0, 7) == 0) ? 8'h3D : 8'h30 + 8'($urandom_range(0, 9));
            model_stream();
            res = 7'($urandom);
            e   = ($urandom_range(0, 1) == 1) ? res : 7'($urandom);
            do_load_start(1'($urandom_range(0, 1)), e);
            do_stream();
            do_wait(int'($urandom_range(0, 20)), res);
            for (int j = 0; j < 3; j++) begin
                valid_in = 1'($urandom_range(0, 1)); result_in = 7'($urandom);
                tick();
                check("idle_valid_ignored_done", 32'(done), 32'd0);
                check("idle_valid_ignored_res", 32'(result_out), 32'(model_res));
            end
            valid_in = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
